// File: rtl/reg_file_cmd_ctrl.sv
// Byte-stream command front-end for the 8x16 register file.
// Decodes write/read frames and returns read data as two bytes.
module reg_file_cmd_ctrl #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned MEM_WIDTH  = 16,
    parameter int unsigned MEM_DEPTH  = 8,
    parameter logic [7:0]  WR_CMD     = 8'hAA,
    parameter logic [7:0]  RD_CMD     = 8'hBB
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [7:0]            In_Data,
    input  logic                  In_Valid,
    output logic                  In_Ready,
    output logic [7:0]            Out_Data,
    output logic                  Out_Valid,
    input  logic                  Out_Ready,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [MEM_WIDTH-1:0]  WrData,
    input  logic [MEM_WIDTH-1:0]  RdData,
    output logic                  Busy,
    output logic                  Err
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        ADDR   = 4'd1,
        WDAT_L = 4'd2,
        WDAT_H = 4'd3,
        WRITE  = 4'd4,
        READ   = 4'd5,
        RWAIT  = 4'd6,
        TX_L   = 4'd7,
        TX_H   = 4'd8
    } state_t;

    localparam logic [7:0] DEPTH_B = 8'(MEM_DEPTH);

    state_t state;
    state_t state_nxt;

    logic                 wr_flag;
    logic                 wr_flag_nxt;
    logic                 bad_addr;
    logic                 bad_addr_nxt;
    logic [MEM_WIDTH-1:0] rbuf;

    logic xfer;
    logic in_bad;
    logic ld_addr;
    logic ld_lo;
    logic ld_hi;
    logic ld_rbuf;

    assign xfer   = In_Valid & In_Ready;
    assign in_bad = (In_Data >= DEPTH_B);

    // State and frame flags; reset aborts any frame in flight.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= IDLE;
            wr_flag  <= 1'b0;
            bad_addr <= 1'b0;
        end else begin
            state    <= state_nxt;
            wr_flag  <= wr_flag_nxt;
            bad_addr <= bad_addr_nxt;
        end
    end

    // Next-state decode plus all strobes and handshake outputs.
    always_comb begin
        state_nxt    = state;
        wr_flag_nxt  = wr_flag;
        bad_addr_nxt = bad_addr;
        In_Ready     = 1'b0;
        Out_Valid    = 1'b0;
        Out_Data     = 8'h00;
        WrEn         = 1'b0;
        RdEn         = 1'b0;
        Err          = 1'b0;
        ld_addr      = 1'b0;
        ld_lo        = 1'b0;
        ld_hi        = 1'b0;
        ld_rbuf      = 1'b0;
        unique case (state)
            IDLE: begin
                In_Ready = 1'b1;
                if (xfer) begin
                    if (In_Data == WR_CMD) begin
                        wr_flag_nxt = 1'b1;
                        state_nxt   = ADDR;
                    end else if (In_Data == RD_CMD) begin
                        wr_flag_nxt = 1'b0;
                        state_nxt   = ADDR;
                    end else begin
                        Err = 1'b1;
                    end
                end
            end
            ADDR: begin
                In_Ready = 1'b1;
                if (xfer) begin
                    ld_addr      = 1'b1;
                    bad_addr_nxt = in_bad;
                    if (wr_flag) begin
                        state_nxt = WDAT_L;
                    end else if (!in_bad) begin
                        state_nxt = READ;
                    end else begin
                        Err       = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            WDAT_L: begin
                In_Ready = 1'b1;
                if (xfer) begin
                    ld_lo     = 1'b1;
                    state_nxt = WDAT_H;
                end
            end
            WDAT_H: begin
                In_Ready = 1'b1;
                if (xfer) begin
                    ld_hi     = 1'b1;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                WrEn      = ~bad_addr;
                Err       = bad_addr;
                state_nxt = IDLE;
            end
            READ: begin
                RdEn      = 1'b1;
                state_nxt = RWAIT;
            end
            RWAIT: begin
                ld_rbuf   = 1'b1;
                state_nxt = TX_L;
            end
            TX_L: begin
                Out_Valid = 1'b1;
                Out_Data  = rbuf[7:0];
                if (Out_Ready) begin
                    state_nxt = TX_H;
                end
            end
            TX_H: begin
                Out_Valid = 1'b1;
                Out_Data  = rbuf[15:8];
                if (Out_Ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Address/data/response registers hold until the next load.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            Address <= '0;
            WrData  <= '0;
            rbuf    <= '0;
        end else begin
            if (ld_addr) begin
                Address <= In_Data[ADDR_WIDTH-1:0];
            end
            if (ld_lo) begin
                WrData[7:0] <= In_Data;
            end
            if (ld_hi) begin
                WrData[15:8] <= In_Data;
            end
            if (ld_rbuf) begin
                rbuf <= RdData;
            end
        end
    end

    assign Busy = (state != IDLE);

endmodule

// File: tb/tb_reg_file_cmd_ctrl.sv
// Directed bench for reg_file_cmd_ctrl with a small
// register file model answering RdEn/WrEn.
module tb_reg_file_cmd_ctrl;

    logic        CLK;
    logic        RST;
    logic [7:0]  In_Data;
    logic        In_Valid;
    logic        In_Ready;
    logic [7:0]  Out_Data;
    logic        Out_Valid;
    logic        Out_Ready;
    logic        WrEn;
    logic        RdEn;
    logic [3:0]  Address;
    logic [15:0] WrData;
    logic [15:0] RdData;
    logic        Busy;
    logic        Err;

    int n_chk;
    int n_fail;

    reg_file_cmd_ctrl dut (
        .CLK      (CLK),
        .RST      (RST),
        .In_Data  (In_Data),
        .In_Valid (In_Valid),
        .In_Ready (In_Ready),
        .Out_Data (Out_Data),
        .Out_Valid(Out_Valid),
        .Out_Ready(Out_Ready),
        .WrEn     (WrEn),
        .RdEn     (RdEn),
        .Address  (Address),
        .WrData   (WrData),
        .RdData   (RdData),
        .Busy     (Busy),
        .Err      (Err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // register file model: 16 slots so bad addresses cannot alias
    logic [15:0] mem [16];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        RdData = 16'h0000;
    end
    always @(posedge CLK) begin
        if (WrEn) mem[Address] <= WrData;
        if (RdEn) RdData <= mem[Address];
    end

    // event monitor sampled on the falling edge
    int          wr_cnt;
    int          rd_cnt;
    int          err_cnt;
    int          both_cnt;
    logic [3:0]  last_wa;
    logic [15:0] last_wd;
    initial begin
        wr_cnt = 0; rd_cnt = 0; err_cnt = 0; both_cnt = 0;
        last_wa = '0; last_wd = '0;
    end
    always @(negedge CLK) begin
        if (WrEn) begin
            wr_cnt++;
            last_wa = Address;
            last_wd = WrData;
        end
        if (RdEn) rd_cnt++;
        if (Err) err_cnt++;
        if (WrEn && RdEn) both_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0] d;
        logic       v;
        logic       ordy;
        logic       ir;
        logic       bsy;
        logic       err;
        logic       we;
        logic       re;
        logic       ov;
        logic [7:0] od;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] d, input logic v,
                                input logic ordy, input logic ir,
                                input logic bsy, input logic err,
                                input logic we, input logic re,
                                input logic ov, input logic [7:0] od);
        vec_t t;
        t.d = d; t.v = v; t.ordy = ordy; t.ir = ir; t.bsy = bsy;
        t.err = err; t.we = we; t.re = re; t.ov = ov; t.od = od;
        return t;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        In_Data  = b;
        In_Valid = 1'b1;
        while (!In_Ready && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        if (n >= 20) check("send_timeout", 32'd0, 32'd1);
        @(posedge CLK); #1;
        In_Valid = 1'b0;
    endtask

    task automatic recv_byte(output logic [7:0] b);
        int n;
        n = 0;
        Out_Ready = 1'b1;
        while (!Out_Valid && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        if (n >= 20) check("recv_timeout", 32'd0, 32'd1);
        b = Out_Data;
        @(posedge CLK); #1;
        Out_Ready = 1'b0;
    endtask

    task automatic read_reg(input logic [7:0] a, output logic [15:0] d);
        logic [7:0] lo;
        logic [7:0] hi;
        send_byte(8'hBB);
        send_byte(a);
        recv_byte(lo);
        recv_byte(hi);
        d = {hi, lo};
    endtask

    vec_t        tv [30];
    logic [15:0] rd;
    logic [7:0]  b;
    logic [7:0]  stall_bytes [4];
    int          w0;
    int          e0;
    int          n;

    initial begin
        n_chk = 0;
        n_fail = 0;
        //          d     v  or ir bs er we re ov od
        tv[0]  = mk(8'hAA,1,1,1,0,0,0,0,0,8'h00);
        tv[1]  = mk(8'h05,1,1,1,1,0,0,0,0,8'h00);
        tv[2]  = mk(8'h34,1,1,1,1,0,0,0,0,8'h00);
        tv[3]  = mk(8'h12,1,1,1,1,0,0,0,0,8'h00);
        tv[4]  = mk(8'h00,0,1,0,1,0,1,0,0,8'h00);
        tv[5]  = mk(8'hBB,1,1,1,0,0,0,0,0,8'h00);
        tv[6]  = mk(8'h05,1,1,1,1,0,0,0,0,8'h00);
        tv[7]  = mk(8'h00,0,1,0,1,0,0,1,0,8'h00);
        tv[8]  = mk(8'h00,0,1,0,1,0,0,0,0,8'h00);
        tv[9]  = mk(8'h00,0,1,0,1,0,0,0,1,8'h34);
        tv[10] = mk(8'h00,0,1,0,1,0,0,0,1,8'h12);
        tv[11] = mk(8'h00,0,1,1,0,0,0,0,0,8'h00);
        tv[12] = mk(8'h5C,1,1,1,0,1,0,0,0,8'h00);
        tv[13] = mk(8'h00,0,1,1,0,0,0,0,0,8'h00);
        tv[14] = mk(8'hBB,1,1,1,0,0,0,0,0,8'h00);
        tv[15] = mk(8'h08,1,1,1,1,1,0,0,0,8'h00);
        tv[16] = mk(8'h00,0,1,1,0,0,0,0,0,8'h00);
        tv[17] = mk(8'hAA,1,1,1,0,0,0,0,0,8'h00);
        tv[18] = mk(8'h09,1,1,1,1,0,0,0,0,8'h00);
        tv[19] = mk(8'h11,1,1,1,1,0,0,0,0,8'h00);
        tv[20] = mk(8'h22,1,1,1,1,0,0,0,0,8'h00);
        tv[21] = mk(8'h00,0,1,0,1,1,0,0,0,8'h00);
        tv[22] = mk(8'h00,0,1,1,0,0,0,0,0,8'h00);
        tv[23] = mk(8'hBB,1,1,1,0,0,0,0,0,8'h00);
        tv[24] = mk(8'h00,1,1,1,1,0,0,0,0,8'h00);
        tv[25] = mk(8'h00,0,1,0,1,0,0,1,0,8'h00);
        tv[26] = mk(8'h00,0,1,0,1,0,0,0,0,8'h00);
        tv[27] = mk(8'h00,0,1,0,1,0,0,0,1,8'h00);
        tv[28] = mk(8'h00,0,1,0,1,0,0,0,1,8'h00);
        tv[29] = mk(8'h00,0,1,1,0,0,0,0,0,8'h00);

        RST = 1'b0;
        In_Data = 8'h00;
        In_Valid = 1'b0;
        Out_Ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        #3;
        check("reset_outs",
              {24'd0, In_Ready, Busy, Err, WrEn, RdEn, Out_Valid, 2'b0},
              {24'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b0});
        check("reset_addr_data", {12'd0, Address, WrData}, 32'd0);
        check("reset_outdata", {24'd0, Out_Data}, 32'd0);
        @(posedge CLK); #1;

        // reset while a write frame is in flight
        send_byte(8'hAA);
        send_byte(8'h03);
        w0 = wr_cnt;
        RST = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        #3;
        check("midreset_busy", {31'd0, Busy}, 32'd0);
        check("midreset_inrdy", {31'd0, In_Ready}, 32'd1);
        check("midreset_addr", {28'd0, Address}, 32'd0);
        check("midreset_wren", {31'd0, WrEn}, 32'd0);
        @(posedge CLK); #1;
        read_reg(8'h03, rd);
        check("midreset_rd3", {16'd0, rd}, 32'h0000);
        check("midreset_nowr", wr_cnt - w0, 32'd0);

        // cycle-accurate table: write/read, opcode, bad addrs
        w0 = wr_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 30; i++) begin
            In_Data   = tv[i].d;
            In_Valid  = tv[i].v;
            Out_Ready = tv[i].ordy;
            #3;
            n_chk++;
            if ({In_Ready, Busy, Err, WrEn, RdEn, Out_Valid, Out_Data}
                !== {tv[i].ir, tv[i].bsy, tv[i].err, tv[i].we,
                     tv[i].re, tv[i].ov, tv[i].od}) begin
                n_fail++;
                $display("FAIL vec%0d: ir%b bsy%b err%b we%b re%b ov%b od%h exp ir%b bsy%b err%b we%b re%b ov%b od%h",
                         i, In_Ready, Busy, Err, WrEn, RdEn, Out_Valid,
                         Out_Data, tv[i].ir, tv[i].bsy, tv[i].err,
                         tv[i].we, tv[i].re, tv[i].ov, tv[i].od);
            end
            if (i == 4) begin
                check("wr5_addr", {28'd0, Address}, 32'd5);
                check("wr5_data", {16'd0, WrData}, 32'h1234);
            end
            @(posedge CLK); #1;
        end
        In_Valid  = 1'b0;
        Out_Ready = 1'b0;
        check("table_wr_count", wr_cnt - w0, 32'd1);
        check("table_err_count", err_cnt - e0, 32'd3);

        // output backpressure on addr 2
        send_byte(8'hAA);
        send_byte(8'h02);
        send_byte(8'hEF);
        send_byte(8'hBE);
        send_byte(8'hBB);
        send_byte(8'h02);
        n = 0;
        while (!Out_Valid && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        check("bp_wait", {31'd0, Out_Valid}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            #3;
            check("bp_hold", {23'd0, Out_Valid, Out_Data}, {23'd0, 1'b1, 8'hEF});
            @(posedge CLK); #1;
        end
        recv_byte(b);
        check("bp_lo", {24'd0, b}, 32'h000000EF);
        recv_byte(b);
        check("bp_hi", {24'd0, b}, 32'h000000BE);

        // input stalls across a write frame
        stall_bytes[0] = 8'hAA;
        stall_bytes[1] = 8'h06;
        stall_bytes[2] = 8'h5A;
        stall_bytes[3] = 8'hA5;
        w0 = wr_cnt;
        for (int k = 0; k < 4; k++) begin
            In_Valid = 1'b0;
            In_Data  = 8'hFF;
            @(posedge CLK); #1;
            In_Data  = stall_bytes[k];
            In_Valid = 1'b1;
            @(posedge CLK); #1;
        end
        In_Valid = 1'b0;
        #3;
        check("stall_wren", {31'd0, WrEn}, 32'd1);
        @(posedge CLK); #1;
        check("stall_wr_count", wr_cnt - w0, 32'd1);
        check("stall_wr_addr", {28'd0, last_wa}, 32'd6);
        check("stall_wr_data", {16'd0, last_wd}, 32'h0000A55A);
        read_reg(8'h06, rd);
        check("stall_readback", {16'd0, rd}, 32'h0000A55A);
        read_reg(8'h05, rd);
        check("readback5", {16'd0, rd}, 32'h00001234);

        check("wr_rd_exclusive", both_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
